hangman_engine: RTL and testbench

HANGMAN_ENGINE -- requirements
Module: hangman_engine

---
 rtl/hangman_pkg.sv | 18 +
 rtl/hangman_match.sv | 18 +
 rtl/hangman_engine.sv | 137 +++++++++++++
 tb/tb_hangman_engine.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hangman_pkg.sv
// Shared definitions for the hangman engine: state encoding and letter-code constants.
package hangman_pkg;

  localparam int unsigned CHAR_W_DEFAULT = 5;
  localparam int unsigned CODE_NONE      = 0;
  localparam int unsigned CODE_A         = 1;
  localparam int unsigned CODE_Z         = 26;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_GUESS = 3'd2,
    ST_CHECK = 3'd3,
    ST_WIN   = 3'd4,
    ST_LOSE  = 3'd5
  } state_t;

endpackage

// File: rtl/hangman_match.sv
// Compares one letter against every position of the secret word in parallel.
module hangman_match #(
  parameter int unsigned WORD_LEN = 5,
  parameter int unsigned CHAR_W   = 5
) (
  input  logic [WORD_LEN*CHAR_W-1:0] word,
  input  logic [CHAR_W-1:0]          letter,
  output logic [WORD_LEN-1:0]        match
);

  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < WORD_LEN; i++) begin
      match[i] = (word[i*CHAR_W +: CHAR_W] == letter);
    end
  end

endmodule

// File: rtl/hangman_engine.sv
// Hangman game controller: loads a secret word, scores guesses, tracks revealed
// letters and remaining misses, and reports win/lose.
module hangman_engine
  import hangman_pkg::*;
#(
  parameter int unsigned WORD_LEN     = 5,
  parameter int unsigned CHAR_W       = CHAR_W_DEFAULT,
  parameter int unsigned MAX_TRIES    = 7,
  parameter int unsigned REPEAT_COSTS = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               word_valid,
  input  logic [WORD_LEN*CHAR_W-1:0]         word,
  input  logic                               char_valid,
  input  logic [CHAR_W-1:0]                  char_in,
  output logic                               char_ready,
  output logic [WORD_LEN-1:0]                guessed_mask,
  output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left,
  output logic                               hit,
  output logic                               miss,
  output logic                               dup,
  output logic                               bad,
  output logic                               win,
  output logic                               lose,
  output logic                               busy
);

  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

  state_t                       state_q, state_d;
  logic [WORD_LEN-1:0]          mask_q, mask_d;
  logic [TRY_W-1:0]             tries_q, tries_d, tries_dec;
  logic [WORD_LEN*CHAR_W-1:0]   word_q, word_d;
  logic [CHAR_W-1:0]            letter_q, letter_d;
  logic [WORD_LEN-1:0]          match;
  logic                         letter_ok;
  logic                         hit_c, miss_c, dup_c, bad_c;

  hangman_match #(
    .WORD_LEN (WORD_LEN),
    .CHAR_W   (CHAR_W)
  ) u_match (
    .word   (word_q),
    .letter (letter_q),
    .match  (match)
  );

  assign letter_ok = (letter_q >= CHAR_W'(CODE_A)) && (letter_q <= CHAR_W'(CODE_Z));
  assign tries_dec = (tries_q == '0) ? '0 : tries_q - TRY_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mask_q   <= '0;
      tries_q  <= TRY_W'(MAX_TRIES);
      word_q   <= '0;
      letter_q <= CHAR_W'(CODE_NONE);
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      tries_q  <= tries_d;
      word_q   <= word_d;
      letter_q <= letter_d;
    end
  end

  // Next-state and result pulses; start preempts everything, including a pending check.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    tries_d  = tries_q;
    word_d   = word_q;
    letter_d = letter_q;
    hit_c    = 1'b0;
    miss_c   = 1'b0;
    dup_c    = 1'b0;
    bad_c    = 1'b0;
    if (start) begin
      state_d = ST_LOAD;
      mask_d  = '0;
      tries_d = TRY_W'(MAX_TRIES);
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (word_valid) begin
            word_d  = word;
            state_d = ST_GUESS;
          end
        end
        ST_GUESS: begin
          if (char_valid) begin
            letter_d = char_in;
            state_d  = ST_CHECK;
          end
        end
        ST_CHECK: begin
          state_d = ST_GUESS;
          if (!letter_ok) begin
            bad_c = 1'b1;
          end else if (match == '0) begin
            miss_c  = 1'b1;
            tries_d = tries_dec;
            if (tries_dec == '0) state_d = ST_LOSE;
          end else if ((match & ~mask_q) != '0) begin
            hit_c  = 1'b1;
            mask_d = mask_q | match;
            if (&mask_d) state_d = ST_WIN;
          end else begin
            dup_c = 1'b1;
            if (REPEAT_COSTS != 0) begin
              tries_d = tries_dec;
              if (tries_dec == '0) state_d = ST_LOSE;
            end
          end
        end
        ST_IDLE, ST_WIN, ST_LOSE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Result pulses are suppressed while reset is applied so an interrupted check stays silent.
  assign hit  = hit_c  & ~rst;
  assign miss = miss_c & ~rst;
  assign dup  = dup_c  & ~rst;
  assign bad  = bad_c  & ~rst;

  assign char_ready   = (state_q == ST_GUESS);
  assign busy         = (state_q == ST_LOAD) || (state_q == ST_GUESS) || (state_q == ST_CHECK);
  assign win          = (state_q == ST_WIN);
  assign lose         = (state_q == ST_LOSE);
  assign guessed_mask = mask_q;
  assign tries_left   = tries_q;

endmodule

// File: tb/tb_hangman_engine.sv
// Bench for hangman_engine: three instances (default, costed repeats, 1-letter/1-try)
// driven in lockstep and checked against a per-instance game model.
module tb_hangman_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        word_valid = 1'b0;
  logic [24:0] word = '0;
  logic [4:0]  word_s = '0;
  logic        char_valid = 1'b0;
  logic [4:0]  char_in = '0;

  logic [2:0]  hit_v, miss_v, dup_v, bad_v, win_v, lose_v, busy_v, rdy_v;
  logic [4:0]  mask0, mask1;
  logic [0:0]  mask2;
  logic [2:0]  tr0, tr1;
  logic [0:0]  tr2;

  always #5 clk = ~clk;

  hangman_engine #(.WORD_LEN(5), .CHAR_W(5), .MAX_TRIES(7), .REPEAT_COSTS(0)) dut (
    .clk(clk), .rst(rst), .start(start), .word_valid(word_valid), .word(word),
    .char_valid(char_valid), .char_in(char_in), .char_ready(rdy_v[0]),
    .guessed_mask(mask0), .tries_left(tr0), .hit(hit_v[0]), .miss(miss_v[0]),
    .dup(dup_v[0]), .bad(bad_v[0]), .win(win_v[0]), .lose(lose_v[0]), .busy(busy_v[0]));

  hangman_engine #(.WORD_LEN(5), .CHAR_W(5), .MAX_TRIES(7), .REPEAT_COSTS(1)) dut_r (
    .clk(clk), .rst(rst), .start(start), .word_valid(word_valid), .word(word),
    .char_valid(char_valid), .char_in(char_in), .char_ready(rdy_v[1]),
    .guessed_mask(mask1), .tries_left(tr1), .hit(hit_v[1]), .miss(miss_v[1]),
    .dup(dup_v[1]), .bad(bad_v[1]), .win(win_v[1]), .lose(lose_v[1]), .busy(busy_v[1]));

  hangman_engine #(.WORD_LEN(1), .CHAR_W(5), .MAX_TRIES(1), .REPEAT_COSTS(0)) dut_s (
    .clk(clk), .rst(rst), .start(start), .word_valid(word_valid), .word(word_s),
    .char_valid(char_valid), .char_in(char_in), .char_ready(rdy_v[2]),
    .guessed_mask(mask2), .tries_left(tr2), .hit(hit_v[2]), .miss(miss_v[2]),
    .dup(dup_v[2]), .bad(bad_v[2]), .win(win_v[2]), .lose(lose_v[2]), .busy(busy_v[2]));

  int checks = 0;
  int errors = 0;

  // Game model: phase 0 idle, 1 waiting for word, 2 playing, 3 won, 4 lost.
  int len  [3] = '{5, 5, 1};
  int maxt [3] = '{7, 7, 1};
  int rc   [3] = '{0, 1, 0};
  int w    [3][16];
  bit rev  [3][16];
  int tries[3];
  int phase[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] o_mask(int i);
    case (i)
      0:       return 32'(mask0);
      1:       return 32'(mask1);
      default: return 32'(mask2);
    endcase
  endfunction

  function automatic logic [31:0] o_tries(int i);
    case (i)
      0:       return 32'(tr0);
      1:       return 32'(tr1);
      default: return 32'(tr2);
    endcase
  endfunction

  function automatic logic [31:0] o_pulses(int i);
    return 32'({hit_v[i], miss_v[i], dup_v[i], bad_v[i]});
  endfunction

  function automatic logic [31:0] o_flags(int i);
    return 32'({win_v[i], lose_v[i], busy_v[i], rdy_v[i]});
  endfunction

  function automatic logic [31:0] e_mask(int i);
    logic [31:0] m = '0;
    for (int k = 0; k < len[i]; k++) if (rev[i][k]) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] e_flags(int i);
    case (phase[i])
      1:       return 32'h2;
      2:       return 32'h3;
      3:       return 32'h8;
      4:       return 32'h4;
      default: return 32'h0;
    endcase
  endfunction

  // Scores one guess from the game rules; returns {hit,miss,dup,bad}.
  function automatic logic [31:0] classify(int i, int c);
    int n = 0;
    int u = 0;
    if (c < 1 || c > 26) return 32'h1;
    for (int k = 0; k < len[i]; k++) begin
      if (w[i][k] == c) begin
        n++;
        if (!rev[i][k]) u++;
      end
    end
    if (n == 0) return 32'h4;
    if (u > 0)  return 32'h8;
    return 32'h2;
  endfunction

  task automatic apply(int i, int c, logic [31:0] res);
    bit all_rev = 1'b1;
    if (res == 32'h8) begin
      for (int k = 0; k < len[i]; k++) begin
        if (w[i][k] == c) rev[i][k] = 1'b1;
        if (!rev[i][k]) all_rev = 1'b0;
      end
      if (all_rev) phase[i] = 3;
    end else if (res == 32'h4 || (res == 32'h2 && rc[i] != 0)) begin
      if (tries[i] > 0) tries[i]--;
      if (tries[i] == 0) phase[i] = 4;
    end
  endtask

  task automatic m_clear(int i, int ph);
    for (int k = 0; k < 16; k++) rev[i][k] = 1'b0;
    tries[i] = maxt[i];
    phase[i] = ph;
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s[%0d].mask", tag, i), o_mask(i), e_mask(i));
      chk($sformatf("%s[%0d].tries", tag, i), o_tries(i), 32'(tries[i]));
      chk($sformatf("%s[%0d].flags", tag, i), o_flags(i), e_flags(i));
      chk($sformatf("%s[%0d].pulses", tag, i), o_pulses(i), 32'h0);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) m_clear(i, 0);
    #1 check_all(tag);
  endtask

  task automatic new_game(input logic [24:0] wv, input logic [4:0] ws);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) m_clear(i, 1);
    #1 check_all("load");
    word = wv;
    word_s = ws;
    word_valid = 1'b1;
    @(posedge clk); #1;
    word_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      w[0][k] = int'(wv[k*5 +: 5]);
      w[1][k] = w[0][k];
    end
    w[2][0] = int'(ws);
    for (int i = 0; i < 3; i++) phase[i] = 2;
    #1 check_all("ready");
  endtask

  // One accepted guess: ready before, pulse in the check cycle, state one cycle later.
  task automatic do_guess(input int c, input string tag);
    logic [31:0] res;
    char_in = 5'(c);
    char_valid = 1'b1;
    word_valid = 1'($urandom_range(0, 1));
    word = 25'($urandom);
    word_s = 5'($urandom);
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s[%0d].ready", tag, i), 32'(rdy_v[i]), 32'(phase[i] == 2));
    @(posedge clk); #1;
    char_valid = 1'b0;
    word_valid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      res = (phase[i] == 2) ? classify(i, c) : 32'h0;
      chk($sformatf("%s[%0d].pulse c=%0d", tag, i, c), o_pulses(i), res);
      if (phase[i] == 2) apply(i, c, res);
    end
    @(posedge clk); #2;
    check_all(tag);
  endtask

  initial begin
    logic [24:0] wv;
    int c;

    // Reset, then word bus ignored while idle.
    @(posedge clk); #1;
    do_reset("reset");
    word = 25'h1ABCDEF;
    word_valid = 1'b1;
    @(posedge clk); #1;
    word_valid = 1'b0;
    #1 check_all("idle_word");

    // Win on "notre"; the 1-letter instance loses on its first miss.
    new_game({5'd5, 5'd18, 5'd20, 5'd15, 5'd14}, 5'd5);
    do_guess(14, "win1");
    chk("win1.mask_const", o_mask(0), 32'h01);
    do_guess(15, "win2");
    do_guess(20, "win3");
    do_guess(18, "win4");
    do_guess(5, "win5");
    chk("win.mask_const", o_mask(0), 32'h1F);
    chk("win.tries_const", o_tries(0), 32'd7);
    chk("win.flag_const", 32'(win_v[0]), 32'd1);
    chk("sweep.lose_const", 32'(lose_v[2]), 32'd1);
    do_guess(14, "after_win");

    // Lose on seven misses; the 1-letter instance wins on its only hit.
    new_game({5'd5, 5'd18, 5'd20, 5'd15, 5'd14}, 5'd1);
    foreach (maxt[i]) ;
    for (int g = 0; g < 7; g++) do_guess(g < 4 ? g + 1 : g + 2, "lose");
    chk("lose.flag_const", 32'(lose_v[0]), 32'd1);
    chk("lose.tries_const", o_tries(0), 32'd0);
    chk("sweep.win_const", 32'(win_v[2]), 32'd1);

    // Repeated letters in "speed", then a repeat guess.
    new_game({5'd4, 5'd5, 5'd5, 5'd16, 5'd19}, 5'd4);
    do_guess(5, "speed_hit");
    chk("speed.mask_const", o_mask(0), 32'h0C);
    do_guess(5, "speed_dup");
    chk("dup.free_tries", o_tries(0), 32'd7);
    chk("dup.costed_tries", o_tries(1), 32'd6);

    // Invalid codes.
    do_guess(0, "bad0");
    do_guess(27, "bad27");

    // start during CHECK discards the guess silently.
    char_in = 5'd19;
    char_valid = 1'b1;
    @(posedge clk); #1;
    char_valid = 1'b0;
    start = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("start_check[%0d].pulse", i), o_pulses(i), 32'h0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) m_clear(i, 1);
    #1 check_all("start_check");

    // start and a guess in the same GUESS cycle: start wins.
    new_game({5'd1, 5'd2, 5'd3, 5'd4, 5'd5}, 5'd3);
    char_in = 5'd1;
    char_valid = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    char_valid = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 3; i++) m_clear(i, 1);
    #1 check_all("start_guess");

    // rst mid-CHECK, and rst while in GUESS.
    new_game({5'd1, 5'd2, 5'd3, 5'd4, 5'd5}, 5'd3);
    char_in = 5'd2;
    char_valid = 1'b1;
    @(posedge clk); #1;
    char_valid = 1'b0;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk($sformatf("rst_check[%0d].pulse", i), o_pulses(i), 32'h0);
    do_reset("rst_check");
    new_game({5'd1, 5'd2, 5'd3, 5'd4, 5'd5}, 5'd3);
    do_guess(2, "pre_rst");
    do_reset("rst_guess");

    // Randomized games over a small alphabet to force repeats, hits and invalid codes.
    for (int g = 0; g < 6; g++) begin
      wv = '0;
      for (int k = 0; k < 5; k++) wv[k*5 +: 5] = 5'($urandom_range(1, 8));
      new_game(wv, 5'($urandom_range(1, 8)));
      for (int s = 0; s < 20; s++) begin
        c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(1, 9));
        do_guess(c, $sformatf("rnd%0d", g));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
